out_buf_pkt_ctrl: RTL and testbench
===================================

Name: out_buf_pkt_ctrl

Overview:
- Read-side controller for the output buffer FIFO.
- Drains bytes from the FIFO and frames them into packets for the downstream transmitter, using a valid/ready handshake with sop/eop markers.
- Closes a packet on MAX_PKT bytes, on IDLE_TIMEOUT cycles of FIFO starvation, or on an explicit flush.
- Sits between the FIFO read port and the tx serializer, in the FIFO read clock domain.

Parameters:
MAX_PKT, 64, maximum bytes per packet (2..255)
IDLE_TIMEOUT, 8, consecutive FIFO-empty cycles with a staged byte before that byte is declared last (>=1)

Ports:
clk  in  1  single clock, rising-edge
n_rst  in  1  asynchronous active-low reset
fifo_empty  in  1  FIFO empty flag
fifo_rdata  in  8  FIFO head byte; valid whenever fifo_empty=0
fifo_r_enable  out  1  pops FIFO head at the rising edge (combinational from state/inputs)
flush  in  1  force close of the current packet
tx_ready  in  1  downstream accepts tx_data this cycle
tx_valid  out  1  tx_data is valid
tx_data  out  8  packet byte
tx_sop  out  1  first byte of packet (qualified by tx_valid)
tx_eop  out  1  last byte of packet (qualified by tx_valid)
busy  out  1  state != IDLE
pkt_done  out  1  one-cycle pulse after the final-byte handshake

Behaviour:
- Clock and reset: one clock `clk`; reset `n_rst` is asynchronous, active-low.
- Reset values: all outputs 0; state=IDLE; byte count=0; timer=0; staged byte cleared.
- Reset mid-packet: any staged byte is discarded and is not re-read. The next packet starts with sop.
- FIFO interface is first-word-fall-through. fifo_r_enable is never asserted while fifo_empty=1.
- Handshake: transfer occurs when tx_valid & tx_ready.
  - While tx_valid=1 & tx_ready=0: tx_data, tx_sop and tx_eop are held stable, and no pops occur.
  - tx_ready is ignored while tx_valid=0.
- Registers: stage (8b), cnt (8b, bytes popped in current packet), timer (8b), sop_flag.
- FSM states: IDLE, STAGED, SEND, SEND_LAST.
  - IDLE:
    - If fifo_empty=0: fifo_r_enable=1, stage<=fifo_rdata, cnt<=1, sop_flag<=1, timer<=0, go to STAGED.
    - flush has no effect in IDLE.
  - STAGED (tx_valid=0). Priority order:
    1. cnt==MAX_PKT: load tx_data<=stage, tx_sop<=sop_flag, tx_eop<=1, go to SEND_LAST.
    2. flush=1: same as (1).
    3. fifo_empty=0: load tx_data<=stage, tx_sop<=sop_flag, tx_eop<=0, go to SEND.
    4. timer==IDLE_TIMEOUT-1: same as (1).
    5. Otherwise: timer<=timer+1.
  - SEND (tx_valid=1, tx_eop=0):
    - On tx_ready: fifo_r_enable=1 (FIFO is guaranteed non-empty, since only this block pops), stage<=fifo_rdata, cnt<=cnt+1, sop_flag<=0, timer<=0, go to STAGED.
  - SEND_LAST (tx_valid=1, tx_eop=1):
    - On tx_ready: pkt_done<=1 next cycle, cnt<=0, go to IDLE.
- flush while in SEND or SEND_LAST is ignored; the frame in flight completes normally.
- Throughput: at most one byte per 2 cycles. Minimum latency from fifo_empty falling (in IDLE) to tx_valid is 2 cycles.
- A packet of length 1 carries tx_sop=1 and tx_eop=1 on the same byte.
- Packet length is never 0 and never exceeds MAX_PKT.
- Bytes are emitted in FIFO order, with no loss or duplication outside reset.

Test Plan:
1. Reset: assert n_rst=0 mid-clock with random inputs -> all outputs 0 immediately. After release with fifo_empty=1: tx_valid stays 0 and busy=0.
2. Short packet: FIFO holds 0x00,0x01,0x02; tx_ready=1 -> exactly 3 transfers 0x00(sop),0x01,0x02(eop). The eop byte appears IDLE_TIMEOUT cycles after 0x02 is staged. pkt_done pulses once. busy returns to 0.
3. Length cap: 70 bytes 0x00..0x45 queued, MAX_PKT=64 -> packet A is 0x00(sop)..0x3F(eop), 64 bytes. Packet B is 0x40(sop)..0x45(eop), 6 bytes. Two pkt_done pulses.
4. Backpressure: tx_ready=0 for 5 cycles while 0x10 is presented in SEND -> tx_data=0x10 and sop/eop stable; fifo_r_enable=0 throughout. After tx_ready rises, 0x10 transfers exactly once.
5. Flush: single byte 0xA5 staged, flush=1 at timer=2 -> next cycle tx_valid=1, tx_data=0xA5, tx_sop=1, tx_eop=1. Single transfer, then IDLE.
6. Reset mid-packet: n_rst pulsed low after 3 bytes of a 10-byte burst -> outputs clear. After release, the next emitted byte has tx_sop=1 and is the current FIFO head, not the discarded staged byte.

Source files
------------

// File: rtl/out_buf_pkt_ctrl.sv
// Output buffer read-side packet framer.
// Drains a FWFT FIFO into sop/eop framed valid/ready packets.
module out_buf_pkt_ctrl #(
  parameter int MAX_PKT      = 64,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_r_enable,
  input  logic       flush,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       busy,
  output logic       pkt_done
);

  typedef enum logic [1:0] {
    IDLE,
    STAGED,
    SEND,
    SEND_LAST
  } state_t;

  localparam logic [7:0] MAX_B   = 8'(MAX_PKT);
  localparam logic [7:0] TO_LAST = 8'(IDLE_TIMEOUT - 1);

  state_t     state;
  logic [7:0] stage;
  logic [7:0] cnt;
  logic [7:0] timer;
  logic       sop_flag;
  logic       last_now;

  // Cap and flush win over a waiting byte; timeout only when starved.
  assign last_now = (cnt == MAX_B) || flush ||
                    (fifo_empty && (timer == TO_LAST));

  assign busy = (state != IDLE);

  assign fifo_r_enable = n_rst && !fifo_empty &&
                         ((state == IDLE) ||
                          ((state == SEND) && tx_ready));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      stage    <= 8'd0;
      cnt      <= 8'd0;
      timer    <= 8'd0;
      sop_flag <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            stage    <= fifo_rdata;
            cnt      <= 8'd1;
            sop_flag <= 1'b1;
            timer    <= 8'd0;
            state    <= STAGED;
          end
        end
        STAGED: begin
          if (last_now) begin
            tx_valid <= 1'b1;
            tx_data  <= stage;
            tx_sop   <= sop_flag;
            tx_eop   <= 1'b1;
            state    <= SEND_LAST;
          end else if (!fifo_empty) begin
            tx_valid <= 1'b1;
            tx_data  <= stage;
            tx_sop   <= sop_flag;
            tx_eop   <= 1'b0;
            state    <= SEND;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            stage    <= fifo_rdata;
            cnt      <= cnt + 8'd1;
            sop_flag <= 1'b0;
            timer    <= 8'd0;
            state    <= STAGED;
          end
        end
        SEND_LAST: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            pkt_done <= 1'b1;
            cnt      <= 8'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_buf_pkt_ctrl.sv
// Scoreboard bench for out_buf_pkt_ctrl.
// FIFO model feeds the DUT; transfers are popped against expectations.
module tb_out_buf_pkt_ctrl;

  localparam int MAX_PKT      = 64;
  localparam int IDLE_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_r_enable;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_sop;
  logic       tx_eop;
  logic       busy;
  logic       pkt_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  int rd = 0;
  int wr = 0;

  logic [9:0] exp_q [$];
  logic       mon_en = 1'b0;
  int cyc = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int prev_cyc = 0;
  int last_cyc = 0;

  out_buf_pkt_ctrl #(
    .MAX_PKT(MAX_PKT),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_r_enable(fifo_r_enable),
    .flush(flush),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_sop(tx_sop),
    .tx_eop(tx_eop),
    .busy(busy),
    .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd == wr);
  assign fifo_rdata = mem[rd[7:0]];

  always @(posedge clk) begin
    if (fifo_r_enable === 1'b1 && rd != wr) rd <= rd + 1;
  end

  always @(negedge clk) begin
    logic [9:0] e;
    cyc = cyc + 1;
    if (mon_en && n_rst) begin
      if (pkt_done) done_cnt = done_cnt + 1;
      checks = checks + 1;
      if (fifo_r_enable && fifo_empty) begin
        errors = errors + 1;
        $display("FAIL pop_empty: r_enable=%b empty=%b required no pop",
                 fifo_r_enable, fifo_empty);
      end
      if (tx_valid && tx_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL xfer_extra: got data=%h sop=%b eop=%b required none",
                   tx_data, tx_sop, tx_eop);
        end else begin
          e = exp_q.pop_front();
          if ({tx_data, tx_sop, tx_eop} !== e) begin
            errors = errors + 1;
            $display("FAIL xfer: got data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                     tx_data, tx_sop, tx_eop, e[9:2], e[1], e[0]);
          end
        end
        prev_cyc = last_cyc;
        last_cyc = cyc;
        xfer_cnt = xfer_cnt + 1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr[7:0]] = b;
    wr = wr + 1;
  endtask

  task automatic test_reset();
    tx_ready = 1'($urandom);
    flush    = 1'($urandom);
    #2 n_rst = 1'b0;
    #1;
    checks = checks + 1;
    if ({fifo_r_enable, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_done} !== 14'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got %b required all zero",
               {fifo_r_enable, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_done});
    end
    tx_ready = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks = checks + 1;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL reset_idle: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
      end
    end
  endtask

  task automatic test_short();
    int x0;
    @(posedge clk);
    #1;
    done_cnt = 0;
    x0 = xfer_cnt;
    tx_ready = 1'b1;
    exp_q.push_back({8'h00, 1'b1, 1'b0});
    exp_q.push_back({8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'h02, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) push_byte(8'(i));
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL short_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (xfer_cnt - x0 != 3) begin
      errors = errors + 1;
      $display("FAIL short_count: got %0d required 3", xfer_cnt - x0);
    end
    checks = checks + 1;
    if (last_cyc - prev_cyc != IDLE_TIMEOUT + 1) begin
      errors = errors + 1;
      $display("FAIL short_eop_gap: got %0d required %0d",
               last_cyc - prev_cyc, IDLE_TIMEOUT + 1);
    end
    checks = checks + 1;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL short_done: pkt_done=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_length_cap();
    int x0;
    @(posedge clk);
    #1;
    done_cnt = 0;
    x0 = xfer_cnt;
    tx_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      exp_q.push_back({8'(i), (i == 0 || i == 64), (i == 63 || i == 69)});
      push_byte(8'(i));
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL cap_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (xfer_cnt - x0 != 70 || done_cnt != 2) begin
      errors = errors + 1;
      $display("FAIL cap_done: xfers=%0d pkt_done=%0d required 70 2",
               xfer_cnt - x0, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int x0;
    bit seen;
    @(posedge clk);
    #1;
    done_cnt = 0;
    x0 = xfer_cnt;
    tx_ready = 1'b0;
    exp_q.push_back({8'h10, 1'b1, 1'b0});
    exp_q.push_back({8'h11, 1'b0, 1'b1});
    push_byte(8'h10);
    push_byte(8'h11);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL bp_valid_timeout: tx_valid=%b required 1", tx_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks = checks + 1;
      if ({tx_valid, tx_data, tx_sop, tx_eop, fifo_r_enable} !== {1'b1, 8'h10, 1'b1, 1'b0, 1'b0}) begin
        errors = errors + 1;
        $display("FAIL bp_hold: valid=%b data=%h sop=%b eop=%b ren=%b required 1 10 1 0 0",
                 tx_valid, tx_data, tx_sop, tx_eop, fifo_r_enable);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL bp_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (xfer_cnt - x0 != 2 || done_cnt != 1) begin
      errors = errors + 1;
      $display("FAIL bp_done: xfers=%0d pkt_done=%0d required 2 1", xfer_cnt - x0, done_cnt);
    end
  endtask

  task automatic test_flush();
    bit seen;
    @(posedge clk);
    #1;
    done_cnt = 0;
    tx_ready = 1'b1;
    exp_q.push_back({8'hA5, 1'b1, 1'b1});
    push_byte(8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = fifo_r_enable;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL flush_pop: r_enable=%b required 1", fifo_r_enable);
    end
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (tx_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL flush_pre: tx_valid=%b required 0", tx_valid);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({tx_valid, tx_data, tx_sop, tx_eop} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
      errors = errors + 1;
      $display("FAIL flush_out: valid=%b data=%h sop=%b eop=%b required 1 a5 1 1",
               tx_valid, tx_data, tx_sop, tx_eop);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL flush_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL flush_done: pkt_done=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    @(posedge clk);
    #1;
    done_cnt = 0;
    r0 = rd;
    tx_ready = 1'b1;
    exp_q.push_back({8'h20, 1'b1, 1'b0});
    exp_q.push_back({8'h21, 1'b0, 1'b0});
    exp_q.push_back({8'h22, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + i));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL rmid_timeout: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    #1 n_rst = 1'b0;
    #1;
    checks = checks + 1;
    if ({fifo_r_enable, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_done} !== 14'd0) begin
      errors = errors + 1;
      $display("FAIL rmid_outputs: got %b required all zero",
               {fifo_r_enable, tx_valid, tx_data, tx_sop, tx_eop, busy, pkt_done});
    end
    checks = checks + 1;
    if (rd - r0 != 4) begin
      errors = errors + 1;
      $display("FAIL rmid_pops: got %0d required 4", rd - r0);
    end
    for (int i = 4; i < 10; i++)
      exp_q.push_back({8'(8'h20 + i), (i == 4), (i == 9)});
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL rmid_drain: %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rmid_done: pkt_done=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_length_cap();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
